// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the 7-segment scan driver.
//   Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low,
//   so a 0 bit lights that segment.
// -----------------------------------------------------------------------------
package seg7_pkg;

  // One packed BCD digit.
  typedef logic [3:0] bcd_digit_t;

  // All segments off.
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  // Only segment g lit. Shown for the non-decimal codes 10..15.
  localparam logic [6:0] SEG_DASH    = 7'h3F;

  // Standard decimal glyphs, active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_GLYPH_0 = 7'b1000000;
  localparam logic [6:0] SEG_GLYPH_1 = 7'b1111001;
  localparam logic [6:0] SEG_GLYPH_2 = 7'b0100100;
  localparam logic [6:0] SEG_GLYPH_3 = 7'b0110000;
  localparam logic [6:0] SEG_GLYPH_4 = 7'b0011001;
  localparam logic [6:0] SEG_GLYPH_5 = 7'b0010010;
  localparam logic [6:0] SEG_GLYPH_6 = 7'b0000010;
  localparam logic [6:0] SEG_GLYPH_7 = 7'b1111000;
  localparam logic [6:0] SEG_GLYPH_8 = 7'b0000000;
  localparam logic [6:0] SEG_GLYPH_9 = 7'b0010000;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
//   Purely combinational decoder from one 4-bit code to active-low
//   7-segment drive.
//   Ports:
//     code  in   4  BCD code; 0..9 give decimal glyphs, 10..15 give a dash
//     seg   out  7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  bcd_digit_t  code,
  output logic [6:0]  seg
);

  always_comb begin
    case (code)
      4'd0:    seg = SEG_GLYPH_0;
      4'd1:    seg = SEG_GLYPH_1;
      4'd2:    seg = SEG_GLYPH_2;
      4'd3:    seg = SEG_GLYPH_3;
      4'd4:    seg = SEG_GLYPH_4;
      4'd5:    seg = SEG_GLYPH_5;
      4'd6:    seg = SEG_GLYPH_6;
      4'd7:    seg = SEG_GLYPH_7;
      4'd8:    seg = SEG_GLYPH_8;
      4'd9:    seg = SEG_GLYPH_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexes a packed BCD word onto a common-anode 7-segment display.
//   The display advances one digit per rising edge of slow_clk. slow_clk is
//   sampled in the clk_in domain as a data strobe and is never used as a
//   clock. Words arrive over valid/ready and are double-buffered (shadow ->
//   active) so a displayed frame never mixes two words.
//
//   Optional build macro:
//     LEADING_ZERO_BLANK_EN  blank digits i > 0 that are zero and have only
//                            zero digits above them. Digit 0 is never
//                            blanked; an and dp behave as usual.
//
//   Parameters:
//     NUM_DIGITS  digits scanned, legal range 2..8
//
//   Ports:
//     clk_in     in   1             system clock
//     rst        in   1             synchronous, active-high reset
//     slow_clk   in   1             scan strobe; rising edge advances one digit
//     bcd_in     in   4*NUM_DIGITS  packed BCD, digit 0 in [3:0]
//     bcd_dp     in   NUM_DIGITS    decimal point request per digit, 1 = lit
//     bcd_valid  in   1             bcd_in/bcd_dp valid
//     bcd_ready  out  1             shadow buffer free
//     an         out  NUM_DIGITS    digit enables, active-low, one-hot-low
//     seg        out  7             {g,f,e,d,c,b,a}, active-low
//     dp         out  1             decimal point, active-low
//
//   Handshake: a word transfers on any clk_in edge where bcd_valid and
//   bcd_ready are both high. bcd_ready is the inverse of the shadow-pending
//   flag, so bcd_valid is ignored while a word already waits in the shadow.
//   The producer may drop or change bcd_valid/bcd_in freely when no transfer
//   happens.
// -----------------------------------------------------------------------------
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    slow_clk,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   bcd_dp,
  input  logic                    bcd_valid,
  output logic                    bcd_ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                    slow_q;
  logic [IDX_W-1:0]        idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [4*NUM_DIGITS-1:0] active_bcd;
  logic [NUM_DIGITS-1:0]   active_dp;

  // ---------------------------------------------------------------------------
  // Strobe, handshake and frame-boundary decode
  // ---------------------------------------------------------------------------
  logic tick;
  logic boundary;
  logic accept;
  logic swap;

  assign tick      = slow_clk & ~slow_q;
  assign boundary  = tick & (idx == LAST_IDX);
  assign bcd_ready = ~pending;
  assign accept    = bcd_valid & ~pending;
  // accept and swap can never both be true: accept needs pending low,
  // swap needs it high. A word accepted on a boundary therefore waits
  // a full frame in the shadow.
  assign swap      = boundary & pending;

  // ---------------------------------------------------------------------------
  // Next displayed digit. The output registers load from the post-swap
  // active word so digit 0 of a new frame already shows the new word.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]        idx_nxt;
  logic [4*NUM_DIGITS-1:0] act_bcd_nxt;
  logic [NUM_DIGITS-1:0]   act_dp_nxt;
  bcd_digit_t              act_digit [NUM_DIGITS];
  bcd_digit_t              cur_digit;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_nxt;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [NUM_DIGITS-1:0]   blank_mask;

  always_comb begin
    idx_nxt     = boundary ? '0 : idx + 1'b1;
    act_bcd_nxt = swap ? shadow_bcd : active_bcd;
    act_dp_nxt  = swap ? shadow_dp  : active_dp;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      act_digit[i] = act_bcd_nxt[i*4 +: 4];
    end
    cur_digit = act_digit[idx_nxt];
  end

  bcd_to_seg7 u_dec (
    .code (cur_digit),
    .seg  (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit down; a digit is blanked while
  // every digit from it upward is zero. Digit 0 stays lit regardless.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run & (act_digit[i] == 4'd0);
      blank_mask[i] = zero_run;
    end
  end
`else
  assign blank_mask = '0;
`endif

  always_comb begin
    seg_nxt = blank_mask[idx_nxt] ? SEG_BLANK : dec_seg;
    an_nxt  = ~(NUM_DIGITS'(1) << idx_nxt);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst) begin
      slow_q     <= 1'b0;
      idx        <= '0;
      pending    <= 1'b0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      active_bcd <= '0;
      active_dp  <= '0;
      an         <= '1;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
    end else begin
      slow_q <= slow_clk;

      if (accept) begin
        shadow_bcd <= bcd_in;
        shadow_dp  <= bcd_dp;
        pending    <= 1'b1;
      end else if (swap) begin
        pending    <= 1'b0;
      end

      if (swap) begin
        active_bcd <= shadow_bcd;
        active_dp  <= shadow_dp;
      end

      // Outputs hold between ticks.
      if (tick) begin
        idx <= idx_nxt;
        an  <= an_nxt;
        seg <= seg_nxt;
        dp  <= ~act_dp_nxt[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed self-checking bench for seg7_scan_driver (NUM_DIGITS = 4).
//   Expected values are hand-computed glyph constants. Honours the
//   LEADING_ZERO_BLANK_EN macro when choosing expectations for leading zeros.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int N = 4;

  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30;
  localparam logic [6:0] G4 = 7'h19, G5 = 7'h12, G6 = 7'h02, G7 = 7'h78;
  localparam logic [6:0] G8 = 7'h00, G9 = 7'h10;
  localparam logic [6:0] DASH = 7'h3F, BLANK = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BLANK;
`else
  localparam logic [6:0] LZ = G0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic           clk_in = 1'b0;
  logic           rst;
  logic           slow_clk;
  logic [4*N-1:0] bcd_in;
  logic [N-1:0]   bcd_dp;
  logic           bcd_valid;
  logic           bcd_ready;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp;

  always #5 clk_in = ~clk_in;

  seg7_scan_driver #(.NUM_DIGITS(N)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .slow_clk  (slow_clk),
    .bcd_in    (bcd_in),
    .bcd_dp    (bcd_dp),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];   // {an, seg, dp}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // One slow_clk pulse, high for one clk_in cycle then low for one.
  // Outputs update on the first edge and hold through the second.
  task automatic do_tick();
    slow_clk = 1'b1;
    step();
    slow_clk = 1'b0;
    step();
  endtask

  task automatic check_digit(input string tag, input logic [N-1:0] e_an,
                             input logic [6:0] e_seg, input logic e_dp);
    check({tag, ".an"},  32'(an),  32'(e_an));
    check({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check({tag, ".dp"},  32'(dp),  32'(e_dp));
  endtask

  // Present a word and hold valid until it is accepted, with a cycle bound.
  task automatic load(input logic [4*N-1:0] word, input logic [N-1:0] dps);
    int waited;
    waited = 0;
    while (!bcd_ready && waited < 50) begin
      step();
      waited++;
    end
    if (!bcd_ready) check("load_ready_timeout", 32'(bcd_ready), 32'd1);
    bcd_in    = word;
    bcd_dp    = dps;
    bcd_valid = 1'b1;
    step();
    bcd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [11:0] exp_v;
    rst = 1'b1; slow_clk = 1'b0; bcd_in = '0; bcd_dp = '0; bcd_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // 1. Reset values, held until the first tick.
    check_digit("reset", 4'b1111, BLANK, 1'b1);
    check("reset.ready", 32'(bcd_ready), 32'd1);
    repeat (5) step();
    check_digit("idle", 4'b1111, BLANK, 1'b1);

    // 2. 1234 shows from the frame after the load.
    load(16'h1234, 4'b0000);
    check("t2.ready_low", 32'(bcd_ready), 32'd0);
    exp_q.push_back({4'b1101, G0, 1'b1});
    exp_q.push_back({4'b1011, G0, 1'b1});
    exp_q.push_back({4'b0111, G0, 1'b1});
    exp_q.push_back({4'b1110, G4, 1'b1});
    exp_q.push_back({4'b1101, G3, 1'b1});
    exp_q.push_back({4'b1011, G2, 1'b1});
    exp_q.push_back({4'b0111, G1, 1'b1});
    exp_q.push_back({4'b1110, G4, 1'b1});
    for (int k = 0; k < 8; k++) begin
      do_tick();
      exp_v = exp_q.pop_front();
      check($sformatf("t2.tick%0d", k), 32'({an, seg, dp}), 32'(exp_v));
      if (k == 3) check("t2.ready_back", 32'(bcd_ready), 32'd1);
    end

    // 3. Mid-frame load; second word rejected while pending.
    do_tick();                                    // idx 1, old word
    load(16'h5678, 4'b0000);
    bcd_in = 16'h9999; bcd_valid = 1'b1;
    check("t3.ready_low", 32'(bcd_ready), 32'd0);
    step();
    bcd_valid = 1'b0;
    do_tick(); check_digit("t3.idx2", 4'b1011, G2, 1'b1);
    do_tick(); check_digit("t3.idx3", 4'b0111, G1, 1'b1);
    check("t3.ready_still_low", 32'(bcd_ready), 32'd0);
    do_tick(); check_digit("t3.wrap", 4'b1110, G8, 1'b1);
    check("t3.ready_after_wrap", 32'(bcd_ready), 32'd1);
    do_tick(); check("t3.d1", 32'(seg), 32'(G7));
    do_tick(); check("t3.d2", 32'(seg), 32'(G6));
    do_tick(); check("t3.d3", 32'(seg), 32'(G5));
    do_tick(); check("t3.no9999", 32'(seg), 32'(G8));

    // 4. Dash, decimal point, leading zeros.
    load(16'h00A7, 4'b0010);
    repeat (3) do_tick();                         // finish 5678 frame
    do_tick(); check_digit("t4.d0", 4'b1110, G7,   1'b1);
    do_tick(); check_digit("t4.d1", 4'b1101, DASH, 1'b0);
    do_tick(); check_digit("t4.d2", 4'b1011, LZ,   1'b1);
    do_tick(); check_digit("t4.d3", 4'b0111, LZ,   1'b1);

    // 5. Long slow_clk high gives one advance; registered one-cycle latency.
    slow_clk = 1'b1;
    check("t5.before_edge", 32'(an), 32'(4'b0111));
    step();
    check("t5.after_edge", 32'(an), 32'(4'b1110));
    repeat (99) step();
    check("t5.held_high", 32'(an), 32'(4'b1110));
    check("t5.held_seg", 32'(seg), 32'(G7));
    slow_clk = 1'b0;
    step();

    // Reset mid-frame with a word pending; slow_clk high through reset.
    do_tick();
    load(16'h4321, 4'b1111);
    rst = 1'b1; slow_clk = 1'b1;
    step();
    check_digit("t5.rst", 4'b1111, BLANK, 1'b1);
    check("t5.rst_ready", 32'(bcd_ready), 32'd1);
    rst = 1'b0;
    step();
    check_digit("t5.rst_tick", 4'b1101, LZ, 1'b1);
    slow_clk = 1'b0;
    step();
    repeat (3) do_tick();
    check_digit("t5.discarded", 4'b1110, G0, 1'b1);
    check("t5.ready_after", 32'(bcd_ready), 32'd1);

    // 6. Accept in the exact boundary cycle.
    load(16'h9876, 4'b0000);
    repeat (4) do_tick();
    check("t6.frame_in", 32'(seg), 32'(G6));
    repeat (3) do_tick();                         // idx 3
    slow_clk = 1'b1; bcd_in = 16'h1357; bcd_dp = 4'b0001; bcd_valid = 1'b1;
    step();
    slow_clk = 1'b0; bcd_valid = 1'b0;
    check_digit("t6.boundary", 4'b1110, G6, 1'b1);
    check("t6.accepted", 32'(bcd_ready), 32'd0);
    step();
    do_tick(); check("t6.rep1", 32'(seg), 32'(G7));
    do_tick(); check("t6.rep2", 32'(seg), 32'(G8));
    do_tick(); check("t6.rep3", 32'(seg), 32'(G9));
    do_tick(); check_digit("t6.new", 4'b1110, G7, 1'b0);
    check("t6.ready", 32'(bcd_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
